// File: rtl/tri_bus_arbiter_if.sv
// Requester/bus bundle for the four-way tri-state bus arbiter.
// Requesters (master) drive req and data; the arbiter (slave) returns grant, sel, busy and the shared bus.
interface tri_bus_arbiter_if #(
  parameter int DATA_W = 8
);
  // req[i] is a level request, held until the requester is done. grant[i] is
  // registered; requester i owns the bus while grant[i] is set. Dropping
  // req[i] releases ownership at the next clock edge.
  logic [3:0]        req;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [3:0]        grant;
  logic [1:0]        sel;
  logic [DATA_W-1:0] bus_out;
  logic              busy;

  modport master (
    output req, in0, in1, in2, in3,
    input  grant, sel, bus_out, busy
  );

  modport slave (
    input  req, in0, in1, in2, in3,
    output grant, sel, bus_out, busy
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for four requesters sharing one tri-state bus, with a
// bounded hold time per ownership and a one-cycle turnaround between owners.
module tri_bus_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  tri_bus_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state_o,
  output logic [1:0]          dbg_ptr_o,
  output logic [3:0]          dbg_hold_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  hold_q, hold_d;
  logic [1:0]  winner;
  logic        release_own;

  logic [DATA_W-1:0] din [4];
  tri   [DATA_W-1:0] bus_w;

  // Search order ptr+1, ptr+2, ptr+3, ptr; walking backwards lets the nearest hit win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner      = rr_pick(bus.req, ptr_q);
  assign release_own = !bus.req[sel_q] || (hold_q == 4'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d = OWN;
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          ptr_d   = winner;
          hold_d  = 4'd1;
        end
      end
      OWN: begin
        if (release_own) begin
          state_d = TURN;
          grant_d = '0;
          sel_d   = '0;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + 4'd1;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign din[0] = bus.in0;
  assign din[1] = bus.in1;
  assign din[2] = bus.in2;
  assign din[3] = bus.in3;

  // Enables come straight from grant_q, so an async reset releases the bus at once.
  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign bus_w = grant_q[i] ? din[i] : {DATA_W{1'bz}};
  end

  assign bus.bus_out = bus_w;
  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = (state_q != IDLE);

  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;
  assign dbg_hold_o  = hold_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed vector table plus hand-written sequences
// for rotation, async reset and single-cycle hold.
module tb_tri_bus_arbiter;

  localparam int DW = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic [1:0] state;
    logic [1:0] ptr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state, dbg_ptr, dbg_state1, dbg_ptr1;
  logic [3:0]  dbg_hold, dbg_hold1;
  logic [3:0]  prev_g;
  int          n_vec;
  int          n_err;
  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  logic [DW-1:0] din_tab [4];

  tri_bus_arbiter_if #(.DATA_W(DW)) bif();
  tri_bus_arbiter_if #(.DATA_W(DW)) bif1();

  tri_bus_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bif),
    .dbg_state_o(dbg_state), .dbg_ptr_o(dbg_ptr), .dbg_hold_o(dbg_hold)
  );

  tri_bus_arbiter #(.DATA_W(DW), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bif1),
    .dbg_state_o(dbg_state1), .dbg_ptr_o(dbg_ptr1), .dbg_hold_o(dbg_hold1)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [3:0] g, input logic [DW-1:0] bus);
    logic [DW-1:0] e;
    e = {DW{1'bz}};
    n_vec++;
    if (g == 4'b0000) begin
      if (!(bus === {DW{1'bz}} || bus === {DW{1'b0}})) begin
        n_err++;
        $display("FAIL %s bus: got %h expected %h", name, bus, e);
      end
    end else begin
      for (int i = 0; i < 4; i++) if (g[i]) e = din_tab[i];
      if (bus !== e) begin
        n_err++;
        $display("FAIL %s bus: got %h expected %h", name, bus, e);
      end
    end
  endtask

  // per-cycle protocol checks, run after every active edge
  task automatic monitor();
    chk("onehot0", 32'($countones(bif.grant) <= 1), 32'd1);
    chk("onehot0_h1", 32'($countones(bif1.grant) <= 1), 32'd1);
    if (bif.grant != 4'b0000) chk("bus_known", 32'($isunknown(bif.bus_out)), 32'd0);
    chk("no_overlap", 32'(prev_g != 4'b0000 && bif.grant != 4'b0000 && prev_g != bif.grant), 32'd0);
    prev_g = bif.grant;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic add_vec(input string name, input logic [3:0] req, input logic [3:0] grant,
                         input logic [1:0] sel, input logic busy, input logic [1:0] state,
                         input logic [1:0] ptr);
    vec_t v;
    v.name = name; v.req = req; v.grant = grant; v.sel = sel;
    v.busy = busy; v.state = state; v.ptr = ptr;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_grant"}, 32'(bif.grant), 32'd0);
    chk({name, "_sel"},   32'(bif.sel),   32'd0);
    chk({name, "_busy"},  32'(bif.busy),  32'd0);
    chk({name, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    chk({name, "_hold"},  32'(dbg_hold),  32'd0);
    chk({name, "_ptr"},   32'(dbg_ptr),   32'd3);
    chk_bus(name, 4'b0000, bif.bus_out);
  endtask

  initial begin
    logic [10:0] e;
    logic [1:0]  owners [5];
    n_vec = 0;
    n_err = 0;
    prev_g = 4'b0000;
    din_tab[0] = 8'hA5; din_tab[1] = 8'h3C; din_tab[2] = 8'h96; din_tab[3] = 8'h5A;
    bif.req = 4'b0000;  bif1.req = 4'b0000;
    bif.in0 = din_tab[0]; bif.in1 = din_tab[1]; bif.in2 = din_tab[2]; bif.in3 = din_tab[3];
    bif1.in0 = din_tab[0]; bif1.in1 = din_tab[1]; bif1.in2 = din_tab[2]; bif1.in3 = din_tab[3];

    // reset before any clock edge
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    tick();
    tick();
    rst = 1'b0;

    //       name            req      grant    sel  busy  state   ptr
    add_vec("own0",         4'b0001, 4'b0001, 2'd0, 1'b1, S_OWN,  2'd0);
    add_vec("rel0_turn",    4'b0000, 4'b0000, 2'd0, 1'b1, S_TURN, 2'd0);
    add_vec("rel0_idle",    4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE, 2'd0);
    add_vec("own2",         4'b0100, 4'b0100, 2'd2, 1'b1, S_OWN,  2'd2);
    add_vec("own2_h2",      4'b0101, 4'b0100, 2'd2, 1'b1, S_OWN,  2'd2);
    add_vec("own2_h3",      4'b0101, 4'b0100, 2'd2, 1'b1, S_OWN,  2'd2);
    add_vec("rel2_turn",    4'b0001, 4'b0000, 2'd0, 1'b1, S_TURN, 2'd2);
    add_vec("rel2_idle",    4'b0001, 4'b0000, 2'd0, 1'b0, S_IDLE, 2'd2);
    add_vec("wrap_own0",    4'b0001, 4'b0001, 2'd0, 1'b1, S_OWN,  2'd0);
    add_vec("hold2",        4'b1111, 4'b0001, 2'd0, 1'b1, S_OWN,  2'd0);
    add_vec("hold3",        4'b1111, 4'b0001, 2'd0, 1'b1, S_OWN,  2'd0);
    add_vec("hold4",        4'b1111, 4'b0001, 2'd0, 1'b1, S_OWN,  2'd0);
    add_vec("max_turn",     4'b1111, 4'b0000, 2'd0, 1'b1, S_TURN, 2'd0);
    add_vec("turn_ignore",  4'b1000, 4'b0000, 2'd0, 1'b0, S_IDLE, 2'd0);
    add_vec("rr_own1",      4'b1111, 4'b0010, 2'd1, 1'b1, S_OWN,  2'd1);
    add_vec("rel1_turn",    4'b0000, 4'b0000, 2'd0, 1'b1, S_TURN, 2'd1);
    add_vec("rel1_idle",    4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE, 2'd1);
    add_vec("stay_idle",    4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE, 2'd1);

    foreach (vecs[k]) begin
      bif.req = vecs[k].req;
      exp_q.push_back({vecs[k].state, vecs[k].ptr, vecs[k].busy, vecs[k].sel, vecs[k].grant});
      tick();
      e = exp_q.pop_front();
      chk(vecs[k].name, 32'({dbg_state, dbg_ptr, bif.busy, bif.sel, bif.grant}), 32'(e));
      chk_bus(vecs[k].name, e[3:0], bif.bus_out);
    end

    // full rotation under continuous requests
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.req = 4'b1111;
    owners[0] = 2'd0; owners[1] = 2'd1; owners[2] = 2'd2; owners[3] = 2'd3; owners[4] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        chk($sformatf("rot%0d_grant", k), 32'(bif.grant), 32'(4'b0001 << owners[k]));
        chk($sformatf("rot%0d_sel", k),   32'(bif.sel),   32'(owners[k]));
        chk($sformatf("rot%0d_hold", k),  32'(dbg_hold),  32'(j + 1));
        chk_bus($sformatf("rot%0d", k), 4'b0001 << owners[k], bif.bus_out);
      end
      tick();
      chk($sformatf("rot%0d_turn", k), 32'({dbg_state, bif.busy, bif.grant}), 32'({S_TURN, 1'b1, 4'b0000}));
      chk_bus($sformatf("rot%0d_turn", k), 4'b0000, bif.bus_out);
      tick();
      chk($sformatf("rot%0d_idle", k), 32'({dbg_state, bif.busy, bif.grant}), 32'({S_IDLE, 1'b0, 4'b0000}));
    end

    // async reset while requester 3 owns the bus
    bif.req = 4'b1000;
    tick();
    chk("own3_grant", 32'(bif.grant), 32'(4'b1000));
    chk_bus("own3", 4'b1000, bif.bus_out);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    #1 rst = 1'b0;
    tick();
    chk("post_rst_grant", 32'(bif.grant), 32'(4'b1000));
    chk("post_rst_sel",   32'(bif.sel),   32'd3);
    chk("post_rst_ptr",   32'(dbg_ptr),   32'd3);
    chk_bus("post_rst", 4'b1000, bif.bus_out);

    // single-cycle ownership with MAX_HOLD=1
    bif.req  = 4'b0000;
    bif1.req = 4'b0011;
    tick();
    chk("h1_own0",  32'({dbg_state1, bif1.grant}), 32'({S_OWN, 4'b0001}));
    chk_bus("h1_own0", 4'b0001, bif1.bus_out);
    tick();
    chk("h1_turn0", 32'({dbg_state1, bif1.grant}), 32'({S_TURN, 4'b0000}));
    chk_bus("h1_turn0", 4'b0000, bif1.bus_out);
    tick();
    chk("h1_idle",  32'({dbg_state1, bif1.grant}), 32'({S_IDLE, 4'b0000}));
    tick();
    chk("h1_own1",  32'({dbg_state1, bif1.grant, bif1.sel}), 32'({S_OWN, 4'b0010, 2'd1}));
    chk_bus("h1_own1", 4'b0010, bif1.bus_out);
    tick();
    chk("h1_turn1", 32'({dbg_state1, bif1.grant}), 32'({S_TURN, 4'b0000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of each requester data port and of the shared bus.
REQ-002 Parameter MAX_HOLD, default 4, SHALL set the maximum consecutive grant cycles per ownership; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 req  input  4  SHALL carry the per-requester bus request, bit i for requester i.
REQ-006 in0, in1, in2, in3  input  DATA_W each  SHALL carry the requester data to be driven onto the bus.
REQ-007 grant  output  4  SHALL be the one-hot (or all-zero) registered grant, used as the tri-state buffer enables.
REQ-008 sel  output  2  SHALL be the registered binary index of the current owner, 0 when no owner.
REQ-009 bus_out  output  DATA_W  SHALL be the shared tri-state bus.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-011 Bus drive SHALL be four tri-state buffers, one per requester, with grant[i] as the enable: bus_out = in<i> when grant[i]=1, else all-Z.
REQ-012 grant SHALL never have more than one bit set; zero bits set SHALL give bus_out all-Z.
REQ-013 The FSM SHALL have exactly three states: IDLE, OWN and TURN.
- IDLE: grant=0.
- OWN: grant = one-hot of the owner.
- TURN: grant=0 for exactly one cycle (bus turnaround; no two drivers on consecutive cycles).
REQ-014 IDLE -> OWN SHALL occur at a clock edge where req != 0; grant and sel SHALL update at that same edge (one-cycle request-to-grant latency).
REQ-015 The winner SHALL be chosen round-robin: the first set req bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last owner.
REQ-016 ptr SHALL update to the winner index on every IDLE -> OWN transition.
REQ-017 In OWN, a 4-bit hold counter SHALL load 1 on entry and increment each cycle the state remains OWN.
REQ-018 OWN -> TURN SHALL occur at the first edge where req[owner]=0 or the hold counter equals MAX_HOLD, whichever comes first.
REQ-019 A requester forced out at MAX_HOLD SHALL become lowest priority via ptr, even if its req stays high.
REQ-020 TURN -> IDLE SHALL occur unconditionally on the next edge, so a waiting request is granted two edges after release.
REQ-021 Changes to req bits of non-owners while in OWN or TURN SHALL have no effect until arbitration in IDLE.
REQ-022 sel SHALL equal the owner index in OWN and 0 in IDLE and TURN.
REQ-023 With MAX_HOLD=1, each ownership SHALL last exactly one cycle, followed by TURN.

Reset
REQ-024 While rst=1, outputs SHALL immediately take these values, independent of clk:
- state = IDLE
- grant = 4'b0000, sel = 0, busy = 0
- bus_out = all-Z
- hold counter = 0
- ptr = 3, so requester 0 wins first after reset.
REQ-025 Reset asserted mid-ownership SHALL drop grant asynchronously.
REQ-026 After rst deasserts, the first arbitration SHALL use ptr = 3.

Verification
REQ-027 After reset, req=4'b0001 held, in0=8'hA5 -> next edge grant=0001, sel=0, bus_out=A5, busy=1; req dropped -> TURN (grant=0000, bus_out=Z), then IDLE.
REQ-028 req=4'b1111 held continuously, MAX_HOLD=4 -> owners cycle 0,1,2,3,0.
- Each owner holds exactly 4 cycles.
- Each ownership is followed by one TURN cycle with bus_out=Z.
REQ-029 Owner 2 holding, req=4'b0101 -> when req[2] drops: TURN, then grant=0001 (search from 3 wraps to 0), not 0100.
REQ-030 rst pulsed asynchronously between edges while grant=1000 -> grant=0000 and bus_out=Z before the next edge; after release with req=4'b1000, next grant=1000 and ptr becomes 3.
REQ-031 Throughout all scenarios, a bench assertion SHALL check every cycle:
- grant is one-hot or zero;
- bus_out is never X while grant != 0;
- no cycle has two nonzero grants with different owners back-to-back without an intervening TURN.
